cipher_round_core: RTL and testbench
====================================

Name: cipher_round_core

Overview:
- Iterative toy block-cipher round engine.
- Accepts a plaintext block and key through a valid/ready handshake and applies NUM_ROUNDS key-mixing rounds, one per clock.
- Applies final key whitening, then presents the ciphertext through a valid/ready handshake.
- Sits downstream of the cycling phase sequencer in the crypto datapath; its internal FSM sequences the work that the phase controller schedules.

Parameters:
- BLOCK_W, 32, width of data block and key in bits (must be >= 8).
- NUM_ROUNDS, 4, number of rounds (1..255).
- ROT, 3, left-rotate amount applied to the state each round (0 < ROT < BLOCK_W).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  upstream presents block/key
- in_ready  output  1  core can accept a new job
- in_block  input  BLOCK_W  plaintext block
- in_key  input  BLOCK_W  cipher key
- out_valid  output  1  ciphertext available
- out_ready  input  1  downstream accepts ciphertext
- out_block  output  BLOCK_W  ciphertext
- busy  output  1  high in every state except IDLE

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_block=0, busy=0, round counter=0, state/key registers=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: s<=in_block, k<=in_key, r<=1, go to ROUND.
  - in_valid without acceptance has no effect.
- ROUND, one round per cycle:
  - s<=rotl(s^k, ROT); k<=rotl(k,1) ^ zero_extend(r[7:0]); r<=r+1.
  - After the edge on which r==NUM_ROUNDS, go to DONE.
  - in_ready=0.
- DONE:
  - out_block = s^k, registered on entry and held stable.
  - out_valid=1 and in_ready=0.
  - On out_valid&out_ready: go to IDLE, out_valid<=0. out_block holds its last value until the next DONE entry.
- Latency: out_valid rises exactly NUM_ROUNDS+1 edges after the accepting edge.
- Throughput: one job per NUM_ROUNDS+2 cycles minimum (one bubble in IDLE after handoff; no same-cycle accept in DONE).
- Backpressure: out_ready low holds DONE indefinitely; out_block and out_valid stay stable; in_ready stays 0.
- Input changes while not in IDLE are ignored. No latching occurs outside the acceptance edge.
- Round counter width is 8 bits. NUM_ROUNDS=255 must terminate correctly, with no wrap before exit.
- Reset mid-operation (ROUND or DONE) aborts the job immediately: returns to reset values, and no partial output is presented.
- Default case in FSM: go to IDLE, outputs take their reset values.

Optional Feature:
- Macro: CIPHER_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit, synchronous, active-high).
  - abort=1 at an edge in ROUND or DONE forces IDLE, out_valid<=0, and r<=0; the job is discarded.
  - abort in IDLE has no effect. abort takes priority over acceptance and over out_ready.
- When undefined: no abort port; behaviour exactly as above.

Decomposition:
- Shared package cipher_pkg holds:
  - State encoding constants IDLE=2'd0, ROUND=2'd1, DONE=2'd2, and the state width.
  - A rotl function parameterised by width and amount.
  - Default BLOCK_W/NUM_ROUNDS/ROT constants.
- One natural sub-module: cipher_round_fn, purely combinational (s,k,r -> s_next,k_next). It is reused by a future decrypt/unroll stage; FSM and registers stay in cipher_round_core.

Test Plan:
- NUM_ROUNDS=1, ROT=3; in_block=0x00000001, in_key=0x00000000, out_ready=1 -> out_valid rises 2 edges after accept; out_block=0x00000009.
- NUM_ROUNDS=1; in_block=0x00000000, in_key=0x00000000 -> out_block=0x00000001. Then busy=0 and in_ready=1 one cycle after handoff.
- Default NUM_ROUNDS=4; hold out_ready=0 for 10 cycles after out_valid -> out_block stable, in_ready=0, in_valid pulses ignored. Raising out_ready completes the handoff in one edge.
- Back-to-back: in_valid held high with two jobs, out_ready=1 -> second accept exactly NUM_ROUNDS+2 edges after the first. Results match a reference model.
- Assert reset during ROUND cycle 2 -> all outputs return to reset values asynchronously, with no out_valid. The next job after release produces the correct result.
- With CIPHER_ABORT_EN: abort pulse in ROUND -> IDLE on the next edge, out_valid never asserts, and a subsequent job runs normally.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and helpers for the toy cipher round engine: state encoding,
// default geometry and a width-generic rotate-left.
package cipher_pkg;

    localparam int DEF_BLOCK_W    = 32;
    localparam int DEF_NUM_ROUNDS = 4;
    localparam int DEF_ROT        = 3;

    // Widest block the generic rotate supports.
    localparam int MAX_W   = 256;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rotate the low w bits of x left by amt (0 < amt < w <= MAX_W); upper bits return zero.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input int amt);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        return ((x << amt) | ((x & mask) >> (w - amt))) & mask;
    endfunction

endpackage

// File: rtl/cipher_round_fn.sv
// One key-mixing round, purely combinational, so an unrolled or decrypt stage
// can reuse it without dragging in the sequencing FSM.
module cipher_round_fn
    import cipher_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int ROT     = DEF_ROT
) (
    input  logic [BLOCK_W-1:0] s,
    input  logic [BLOCK_W-1:0] k,
    input  logic [7:0]         r,
    output logic [BLOCK_W-1:0] s_next,
    output logic [BLOCK_W-1:0] k_next
);

    assign s_next = BLOCK_W'(rotl(MAX_W'(s ^ k), BLOCK_W, ROT));
    // The round index is folded into the key so identical rounds never repeat.
    assign k_next = BLOCK_W'(rotl(MAX_W'(k), BLOCK_W, 1)) ^ BLOCK_W'(r);

endmodule

// File: rtl/cipher_round_core.sv
// Iterative cipher engine: accept block/key, run NUM_ROUNDS rounds one per clock,
// whiten and hand off. Define CIPHER_ABORT_EN to add a synchronous job abort input.
module cipher_round_core
    import cipher_pkg::*;
#(
    parameter int BLOCK_W    = DEF_BLOCK_W,
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROT        = DEF_ROT
) (
    input  logic               clock,
    input  logic               reset,
`ifdef CIPHER_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               busy
);

    state_t             state;
    logic [BLOCK_W-1:0] s;
    logic [BLOCK_W-1:0] k;
    logic [7:0]         r;
    logic [BLOCK_W-1:0] s_next;
    logic [BLOCK_W-1:0] k_next;
    logic               abort_hit;

`ifdef CIPHER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    cipher_round_fn #(
        .BLOCK_W (BLOCK_W),
        .ROT     (ROT)
    ) u_round (
        .s      (s),
        .k      (k),
        .r      (r),
        .s_next (s_next),
        .k_next (k_next)
    );

    // NOTE: every register, outputs included, uses <= so all reads in this block see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            k         <= '0;
            r         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_block <= '0;
            busy      <= 1'b0;
        end else if (abort_hit && state != IDLE) begin
            state     <= IDLE;
            r         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        s        <= in_block;
                        k        <= in_key;
                        r        <= 8'd1;
                        state    <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ROUND: begin
                    s <= s_next;
                    k <= k_next;
                    r <= r + 8'd1;
                    // Whitening is taken from the final round's results so out_block is ready on DONE entry.
                    if (r == 8'(NUM_ROUNDS)) begin
                        state     <= DONE;
                        out_block <= s_next ^ k_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    r         <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_block <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_round_core.sv
// Bench for cipher_round_core: a one-round instance and a default four-round instance,
// checked against a behavioural model of the cipher.
module tb_cipher_round_core;

    localparam int W   = 32;
    localparam int ROT = 3;
    localparam int N_A = 1;
    localparam int N_B = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic         in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [W-1:0] in_block_a = '0, in_key_a = '0;
    logic         in_ready_a, out_valid_a, busy_a;
    logic [W-1:0] out_block_a;

    logic         in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [W-1:0] in_block_b = '0, in_key_b = '0;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [W-1:0] out_block_b;

`ifdef CIPHER_ABORT_EN
    logic abort_a = 1'b0, abort_b = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;
    int unsigned acc_q[$];
    logic [W-1:0] out_q[$];

    cipher_round_core #(.BLOCK_W(W), .NUM_ROUNDS(N_A), .ROT(ROT)) dut_a (
`ifdef CIPHER_ABORT_EN
        .abort     (abort_a),
`endif
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_block  (in_block_a),
        .in_key    (in_key_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_block (out_block_a),
        .busy      (busy_a)
    );

    cipher_round_core #(.BLOCK_W(W), .NUM_ROUNDS(N_B), .ROT(ROT)) dut_b (
`ifdef CIPHER_ABORT_EN
        .abort     (abort_b),
`endif
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_block  (in_block_b),
        .in_key    (in_key_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_block (out_block_b),
        .busy      (busy_b)
    );

    always #5 clock = ~clock;

    // Handshake monitor on the four-round instance: edge index of each accept and each delivered block.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && in_valid_b && in_ready_b) acc_q.push_back(cyc);
        if (!reset && out_valid_b && out_ready_b) out_q.push_back(out_block_b);
    end

    function automatic logic [W-1:0] rot_left(input logic [W-1:0] x, input int n);
        return (x << n) | (x >> (W - n));
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] key, input int rounds);
        logic [W-1:0] s;
        logic [W-1:0] k;
        s = b;
        k = key;
        for (int i = 1; i <= rounds; i++) begin
            s = rot_left(s ^ k, ROT);
            k = rot_left(k, 1) ^ W'(i & 255);
        end
        return s ^ k;
    endfunction

    // Latency counts the accepting edge as edge 1; ok drops if a bounded wait expires.
    task automatic run_job_a(input logic [W-1:0] b, input logic [W-1:0] key, input int hold,
                             output int lat, output logic [W-1:0] got, output bit ok);
        ok = 1'b1; lat = 0; got = '0;
        @(negedge clock);
        for (int t = 0; t < 50 && !in_ready_a; t++) @(negedge clock);
        if (!in_ready_a) begin ok = 1'b0; return; end
        in_block_a = b; in_key_a = key; in_valid_a = 1'b1; out_ready_a = 1'b0;
        @(posedge clock); lat = 1;
        @(negedge clock); in_valid_a = 1'b0; in_block_a = $urandom; in_key_a = $urandom;
        while (!out_valid_a && lat < 600) begin @(posedge clock); lat++; @(negedge clock); end
        if (!out_valid_a) begin ok = 1'b0; return; end
        got = out_block_a;
        repeat (hold) @(negedge clock);
        out_ready_a = 1'b1;
        @(posedge clock);
        @(negedge clock); out_ready_a = 1'b0;
    endtask

    task automatic run_job_b(input logic [W-1:0] b, input logic [W-1:0] key, input int hold,
                             output int lat, output logic [W-1:0] got, output bit ok);
        ok = 1'b1; lat = 0; got = '0;
        @(negedge clock);
        for (int t = 0; t < 50 && !in_ready_b; t++) @(negedge clock);
        if (!in_ready_b) begin ok = 1'b0; return; end
        in_block_b = b; in_key_b = key; in_valid_b = 1'b1; out_ready_b = 1'b0;
        @(posedge clock); lat = 1;
        @(negedge clock); in_valid_b = 1'b0; in_block_b = $urandom; in_key_b = $urandom;
        while (!out_valid_b && lat < 600) begin @(posedge clock); lat++; @(negedge clock); end
        if (!out_valid_b) begin ok = 1'b0; return; end
        got = out_block_b;
        repeat (hold) @(negedge clock);
        out_ready_b = 1'b1;
        @(posedge clock);
        @(negedge clock); out_ready_b = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        tests++;
        if ({in_ready_a, out_valid_a, busy_a} !== 3'b100 || out_block_a !== '0) begin
            fails++;
            $display("FAIL reset_a: ready/valid/busy=%b block=%h, required 100 and 0", {in_ready_a, out_valid_a, busy_a}, out_block_a);
        end
        tests++;
        if ({in_ready_b, out_valid_b, busy_b} !== 3'b100 || out_block_b !== '0) begin
            fails++;
            $display("FAIL reset_b: ready/valid/busy=%b block=%h, required 100 and 0", {in_ready_b, out_valid_b, busy_b}, out_block_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_round();
        int lat; logic [W-1:0] got; bit ok;
        logic [W-1:0] req [2];
        logic [W-1:0] blk [2];
        req[0] = 32'h0000_0009; blk[0] = 32'h0000_0001;
        req[1] = 32'h0000_0001; blk[1] = 32'h0000_0000;
        for (int j = 0; j < 2; j++) begin
            run_job_a(blk[j], '0, 0, lat, got, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL single_timeout: job %0d did not complete", j); end
            tests++;
            if (lat !== N_A + 1) begin fails++; $display("FAIL single_latency: %0d edges, required %0d", lat, N_A + 1); end
            tests++;
            if (got !== req[j] || got !== model(blk[j], '0, N_A)) begin
                fails++; $display("FAIL single_block: got %h, required %h", got, req[j]);
            end
            tests++;
            if ({in_ready_a, busy_a, out_valid_a} !== 3'b100) begin
                fails++; $display("FAIL single_handoff: ready/busy/valid=%b, required 100", {in_ready_a, busy_a, out_valid_a});
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] got, b, key; bit ok;
        for (int j = 0; j < 8; j++) begin
            b = $urandom; key = $urandom;
            run_job_b(b, key, $urandom_range(0, 3), lat, got, ok);
            tests++;
            if (!ok || lat !== N_B + 1) begin
                fails++; $display("FAIL random_latency: ok=%0d %0d edges, required %0d", ok, lat, N_B + 1);
            end
            tests++;
            if (got !== model(b, key, N_B)) begin
                fails++; $display("FAIL random_block: in %h key %h got %h, required %h", b, key, got, model(b, key, N_B));
            end
            tests++;
            if ({in_ready_b, busy_b} !== 2'b10) begin
                fails++; $display("FAIL random_idle: ready/busy=%b, required 10", {in_ready_b, busy_b});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] b, key, exp;
        int lat;
        b = $urandom; key = $urandom; exp = model(b, key, N_B);
        @(negedge clock);
        in_block_b = b; in_key_b = key; in_valid_b = 1'b1; out_ready_b = 1'b0;
        @(posedge clock);
        @(negedge clock); in_valid_b = 1'b0;
        lat = 1;
        while (!out_valid_b && lat < 600) begin @(posedge clock); lat++; @(negedge clock); end
        for (int i = 0; i < 10; i++) begin
            in_valid_b = 1'(i % 2); in_block_b = $urandom; in_key_b = $urandom;
            @(negedge clock);
            tests++;
            if (out_valid_b !== 1'b1 || in_ready_b !== 1'b0 || busy_b !== 1'b1 || out_block_b !== exp) begin
                fails++;
                $display("FAIL backpressure_hold: cycle %0d valid=%b ready=%b busy=%b block=%h, required 1 0 1 %h",
                         i, out_valid_b, in_ready_b, busy_b, out_block_b, exp);
            end
        end
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        @(posedge clock);
        @(negedge clock); out_ready_b = 1'b0;
        tests++;
        if ({out_valid_b, in_ready_b, busy_b} !== 3'b010) begin
            fails++; $display("FAIL backpressure_release: valid/ready/busy=%b, required 010", {out_valid_b, in_ready_b, busy_b});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] b1, k1, b2, k2;
        b1 = $urandom; k1 = $urandom; b2 = $urandom; k2 = $urandom;
        @(negedge clock);
        acc_q.delete(); out_q.delete();
        in_block_b = b1; in_key_b = k1; in_valid_b = 1'b1; out_ready_b = 1'b1;
        for (int t = 0; t < 20 && acc_q.size() < 1; t++) @(negedge clock);
        in_block_b = b2; in_key_b = k2;
        for (int t = 0; t < 30 && acc_q.size() < 2; t++) @(negedge clock);
        in_valid_b = 1'b0;
        for (int t = 0; t < 30 && out_q.size() < 2; t++) @(negedge clock);
        out_ready_b = 1'b0;
        tests++;
        if (acc_q.size() != 2 || out_q.size() != 2) begin
            fails++; $display("FAIL b2b_count: %0d accepts %0d outputs, required 2 and 2", acc_q.size(), out_q.size());
        end else begin
            tests++;
            if (acc_q[1] - acc_q[0] != N_B + 2) begin
                fails++; $display("FAIL b2b_spacing: %0d edges, required %0d", acc_q[1] - acc_q[0], N_B + 2);
            end
            tests++;
            if (out_q[0] !== model(b1, k1, N_B) || out_q[1] !== model(b2, k2, N_B)) begin
                fails++; $display("FAIL b2b_blocks: got %h %h, required %h %h",
                                  out_q[0], out_q[1], model(b1, k1, N_B), model(b2, k2, N_B));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] got, b, key; bit ok; bit saw_valid;
        @(negedge clock);
        in_block_b = $urandom; in_key_b = $urandom; in_valid_b = 1'b1;
        @(posedge clock);
        @(negedge clock); in_valid_b = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({in_ready_b, out_valid_b, busy_b} !== 3'b100 || out_block_b !== '0) begin
            fails++;
            $display("FAIL reset_mid_async: ready/valid/busy=%b block=%h, required 100 and 0", {in_ready_b, out_valid_b, busy_b}, out_block_b);
        end
        saw_valid = 1'b0;
        repeat (3) begin @(negedge clock); if (out_valid_b) saw_valid = 1'b1; end
        reset = 1'b0;
        repeat (6) begin @(negedge clock); if (out_valid_b) saw_valid = 1'b1; end
        tests++;
        if (saw_valid) begin fails++; $display("FAIL reset_mid_novalid: out_valid seen 1, required 0"); end
        b = $urandom; key = $urandom;
        run_job_b(b, key, 1, lat, got, ok);
        tests++;
        if (!ok || got !== model(b, key, N_B)) begin
            fails++; $display("FAIL reset_mid_next: ok=%0d got %h, required %h", ok, got, model(b, key, N_B));
        end
    endtask

`ifdef CIPHER_ABORT_EN
    task automatic test_abort();
        int lat; logic [W-1:0] got, b, key; bit ok; bit saw_valid;
        @(negedge clock);
        in_block_b = $urandom; in_key_b = $urandom; in_valid_b = 1'b1; out_ready_b = 1'b1;
        @(posedge clock);
        @(negedge clock); in_valid_b = 1'b0;
        @(posedge clock);
        @(negedge clock); abort_b = 1'b1;
        @(posedge clock);
        @(negedge clock); abort_b = 1'b0;
        tests++;
        if ({in_ready_b, busy_b, out_valid_b} !== 3'b100) begin
            fails++; $display("FAIL abort_idle: ready/busy/valid=%b, required 100", {in_ready_b, busy_b, out_valid_b});
        end
        saw_valid = 1'b0;
        repeat (8) begin @(negedge clock); if (out_valid_b) saw_valid = 1'b1; end
        out_ready_b = 1'b0;
        tests++;
        if (saw_valid) begin fails++; $display("FAIL abort_novalid: out_valid seen 1, required 0"); end
        b = $urandom; key = $urandom;
        run_job_b(b, key, 0, lat, got, ok);
        tests++;
        if (!ok || lat !== N_B + 1 || got !== model(b, key, N_B)) begin
            fails++; $display("FAIL abort_next: ok=%0d lat=%0d got %h, required %0d %h", ok, lat, got, N_B + 1, model(b, key, N_B));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_round();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef CIPHER_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
